// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent byte transmitter and receiver sharing one clock and baud setting.
// TX launches on a rising edge of uart_en; RX samples each bit once at its midpoint.
//
// state        | meaning
// TX_IDLE      | line high, waiting for a uart_en rising edge
// TX_SEND      | shifting out start, 8 data bits (LSB first) and stop
// RX_IDLE      | waiting for a falling edge on the synchronized line
// RX_RECV      | sampling start, data and stop bits at mid-bit
// RX_WAIT_HIGH | stop bit was low; waiting for the line to return high
module uart_transceiver #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int UART_BPS = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_en,
   input  logic [7:0] uart_din,
   output logic       uart_tx_busy,
   output logic       uart_txd,
   input  logic       uart_rxd,
   output logic       uart_done,
   output logic [7:0] uart_data,
   output logic       uart_rx_busy,
   output logic       frame_err
);
   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CW = $clog2(BPS_CNT);
   localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);
   localparam logic [CW-1:0] CNT_MID = CW'(BPS_CNT / 2);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_WAIT_HIGH} rx_state_t;

   tx_state_t     tx_state_q, tx_state_d;
   logic          en_d0_q, en_d1_q;
   logic [9:0]    tx_frame_q, tx_frame_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic          tx_start;

   rx_state_t     rx_state_q, rx_state_d;
   logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_done_q, rx_done_d;
   logic          rx_err_q, rx_err_d;

   assign tx_start = en_d0_q & ~en_d1_q & (tx_state_q == TX_IDLE);

   // The frame register shifts in ones, so it is all-ones (line idle) once the stop bit ends.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_frame_d = tx_frame_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      unique case (tx_state_q)
         TX_IDLE: begin
            if (tx_start) begin
               tx_state_d = TX_SEND;
               tx_frame_d = {1'b1, uart_din, 1'b0};
               tx_cnt_d   = CNT_MAX;
               tx_bit_d   = '0;
            end
         end
         TX_SEND: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d   = CNT_MAX;
               tx_frame_d = {1'b1, tx_frame_q[9:1]};
               if (tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
               else                  tx_bit_d   = tx_bit_q + 4'd1;
            end else begin
               tx_cnt_d = tx_cnt_q - CW'(1);
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_done_d  = 1'b0;
      rx_err_d   = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rxd_s3_q & ~rxd_s2_q) begin
               rx_state_d = RX_RECV;
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
            end
         end
         RX_RECV: begin
            if (rx_cnt_q == CNT_MAX) begin
               rx_cnt_d = '0;
               rx_bit_d = rx_bit_q + 4'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
            // Leaving at mid-stop leaves half a bit to re-arm for a back-to-back start edge.
            if (rx_cnt_q == CNT_MID) begin
               if (rx_bit_q == 4'd0) begin
                  if (rxd_s2_q) rx_state_d = RX_IDLE;
               end else if (rx_bit_q == 4'd9) begin
                  if (rxd_s2_q) begin
                     rx_data_d  = rx_shift_q;
                     rx_done_d  = 1'b1;
                     rx_state_d = RX_IDLE;
                  end else begin
                     rx_err_d   = 1'b1;
                     rx_state_d = RX_WAIT_HIGH;
                  end
               end else begin
                  rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (rxd_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         en_d0_q    <= 1'b0;
         en_d1_q    <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_frame_q <= '1;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_s3_q   <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_done_q  <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         en_d0_q    <= uart_en;
         en_d1_q    <= en_d0_q;
         tx_state_q <= tx_state_d;
         tx_frame_q <= tx_frame_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         rxd_s1_q   <= uart_rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_s3_q   <= rxd_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_done_q  <= rx_done_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign uart_txd     = tx_frame_q[0];
   assign uart_tx_busy = (tx_state_q == TX_SEND);
   assign uart_rx_busy = (rx_state_q == RX_RECV);
   assign uart_done    = rx_done_q;
   assign uart_data    = rx_data_q;
   assign frame_err    = rx_err_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver at 10 clocks per bit: TX waveform, loopback, framing errors, glitches, reset.
module tb_uart_transceiver;
   localparam int CLK_FREQ = 1_000_000;
   localparam int UART_BPS = 100_000;
   localparam int BPS      = CLK_FREQ / UART_BPS;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       uart_en = 1'b0;
   logic [7:0] uart_din = 8'h00;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rxd_mux;
   logic       uart_tx_busy, uart_txd, uart_done, uart_rx_busy, frame_err;
   logic [7:0] uart_data;

   assign rxd_mux = loop_en ? uart_txd : rxd_drv;

   uart_transceiver #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_en(uart_en), .uart_din(uart_din),
      .uart_tx_busy(uart_tx_busy), .uart_txd(uart_txd), .uart_rxd(rxd_mux),
      .uart_done(uart_done), .uart_data(uart_data), .uart_rx_busy(uart_rx_busy),
      .frame_err(frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct { logic is_err; logic [7:0] data; } exp_t;
   typedef struct { logic [7:0] data; logic stop; } rx_vec_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         failures = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] last_good = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done/err strobe must match the oldest queued expectation.
   always @(negedge sys_clk) begin
      exp_t e;
      if (!sys_rst && (uart_done === 1'b1 || frame_err === 1'b1)) begin
         if (uart_done) done_cnt++;
         if (frame_err) err_cnt++;
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", {uart_done, frame_err}, 2'b00);
         end else begin
            e = sb_q.pop_front();
            check("strobe_kind", {uart_done, frame_err}, e.is_err ? 2'b01 : 2'b10);
            check("rx_data", uart_data, e.data);
         end
      end
   end

   task automatic pulse_en(input logic [7:0] d, input int len);
      @(negedge sys_clk);
      uart_din = d;
      uart_en  = 1'b1;
      repeat (len) @(negedge sys_clk);
      uart_en  = 1'b0;
   endtask

   task automatic wait_tx_busy(input logic lvl, input int limit);
      int n = 0;
      while (uart_tx_busy !== lvl && n < limit) begin
         @(negedge sys_clk);
         n++;
      end
      check("tx_busy_wait", uart_tx_busy, lvl);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rxd_drv = f[b];
         repeat (BPS) @(negedge sys_clk);
      end
      rxd_drv = 1'b1;
      repeat (2 * BPS) @(negedge sys_clk);
   endtask

   task automatic loop_send(input logic [7:0] d);
      sb_q.push_back('{is_err: 1'b0, data: d});
      last_good = d;
      pulse_en(d, 1);
      wait_tx_busy(1'b1, 20);
      wait_tx_busy(1'b0, 12 * BPS);
   endtask

   initial begin
      rx_vec_t    vecs[5];
      logic [7:0] loop_bytes[7];
      logic [7:0] tx_byte;
      logic       exp_bit;
      int         busy_cnt, done_base, err_base;

      // Reset and idle
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         repeat (10) @(negedge sys_clk);
         check("idle_txd", uart_txd, 1'b1);
         check("idle_tx_busy", uart_tx_busy, 1'b0);
         check("idle_rx_busy", uart_rx_busy, 1'b0);
         check("idle_done", uart_done, 1'b0);
         check("idle_data", uart_data, 8'h00);
      end

      // TX waveform of A5, with a second uart_en pulse during busy
      tx_byte = 8'hA5;
      pulse_en(tx_byte, 2);
      wait_tx_busy(1'b1, 20);
      busy_cnt = 0;
      for (int k = 0; k < 200; k++) begin
         if (k < 10 * BPS && (k % BPS) == BPS / 2) begin
            if (k / BPS == 0)      exp_bit = 1'b0;
            else if (k / BPS == 9) exp_bit = 1'b1;
            else                   exp_bit = tx_byte[k / BPS - 1];
            check($sformatf("tx_bit%0d", k / BPS), uart_txd, exp_bit);
         end
         if (k == 30) uart_en = 1'b1;
         if (k == 32) uart_en = 1'b0;
         if (uart_tx_busy) busy_cnt++;
         @(negedge sys_clk);
      end
      check("tx_busy_len", busy_cnt, 10 * BPS);
      check("tx_idle_after", uart_txd, 1'b1);

      // Loopback
      loop_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h02};
      loop_en   = 1'b1;
      done_base = done_cnt;
      err_base  = err_cnt;
      for (int i = 0; i < 7; i++) loop_send(loop_bytes[i]);
      repeat (20) @(negedge sys_clk);
      check("loop_done_count", done_cnt - done_base, 7);
      check("loop_err_count", err_cnt - err_base, 0);
      check("loop_sb_empty", sb_q.size(), 0);
      loop_en = 1'b0;

      // Table of driven RX frames, some with a low stop bit
      vecs[0] = '{data: 8'h3C, stop: 1'b0};
      vecs[1] = '{data: 8'h81, stop: 1'b1};
      vecs[2] = '{data: 8'hFF, stop: 1'b1};
      vecs[3] = '{data: 8'h00, stop: 1'b0};
      vecs[4] = '{data: 8'h7E, stop: 1'b1};
      err_base = err_cnt;
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].stop) begin
            last_good = vecs[i].data;
            sb_q.push_back('{is_err: 1'b0, data: vecs[i].data});
         end else begin
            sb_q.push_back('{is_err: 1'b1, data: last_good});
         end
         send_rx(vecs[i].data, vecs[i].stop);
         check($sformatf("vec%0d_data_hold", i), uart_data, last_good);
      end
      check("vec_err_count", err_cnt - err_base, 2);
      check("vec_sb_empty", sb_q.size(), 0);

      // 3-clock glitch on the RX line
      @(negedge sys_clk);
      rxd_drv = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("glitch_rx_busy_hi", uart_rx_busy, 1'b1);
      rxd_drv = 1'b1;
      repeat (8) @(negedge sys_clk);
      check("glitch_rx_busy_lo", uart_rx_busy, 1'b0);
      repeat (2 * BPS) @(negedge sys_clk);
      last_good = 8'hC3;
      sb_q.push_back('{is_err: 1'b0, data: 8'hC3});
      send_rx(8'hC3, 1'b1);
      check("glitch_sb_empty", sb_q.size(), 0);

      // Reset mid-TX and mid-RX
      pulse_en(8'h99, 1);
      repeat (20) @(negedge sys_clk);
      rxd_drv = 1'b0;
      repeat (25) @(negedge sys_clk);
      check("pre_rst_tx_busy", uart_tx_busy, 1'b1);
      check("pre_rst_rx_busy", uart_rx_busy, 1'b1);
      sys_rst = 1'b1;
      rxd_drv = 1'b1;
      @(negedge sys_clk);
      sys_rst   = 1'b0;
      last_good = 8'h00;
      check("rst_txd", uart_txd, 1'b1);
      check("rst_tx_busy", uart_tx_busy, 1'b0);
      check("rst_rx_busy", uart_rx_busy, 1'b0);
      check("rst_done", uart_done, 1'b0);
      check("rst_data", uart_data, 8'h00);
      repeat (15 * BPS) @(negedge sys_clk);
      check("post_rst_txd", uart_txd, 1'b1);
      check("post_rst_tx_busy", uart_tx_busy, 1'b0);
      loop_en = 1'b1;
      loop_send(8'h5A);
      repeat (20) @(negedge sys_clk);
      check("rst_roundtrip_data", uart_data, 8'h5A);
      check("final_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
